// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
// owns the {S,Z,C,O} flag register and resolves branches from the registered flags.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | wait for imem_ready, load IR and advance PC
// S_DECODE | legality check; illegal encodings divert to S_HALT
// S_EXEC   | drive ALU control, update flags, resolve branches
// S_MEM    | LM read in flight, hold until mem_ready
// S_WB     | first (or only) register write
// S_WB2    | second XCHG write, kept in its own cycle
// S_HALT   | absorbing after an illegal decode, only reset exits
module mc_control_unit #(
   parameter int FUNCT_W  = 9,
   parameter int ALUCTL_W = 5,
   parameter int FLAG_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                imem_ready,
   input  logic                mem_ready,
   input  logic [FLAG_W-1:0]   alu_flags,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                alu_src,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic                imm_src,
   output logic                mem_read,
   output logic                reg_write,
   output logic                reg_write_sel,
   output logic                wb_src,
   output logic [FLAG_W-1:0]   flags_q,
   output logic                illegal,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WB2, S_HALT
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [FLAG_W-1:0]   r_flags;
   logic                r_illegal;

   logic [4:0] w_code;
   logic [3:0] w_sub;
   logic       w_is_lm;
   logic       w_is_li;
   logic       w_is_br;
   logic       w_is_xchg;
   logic       w_is_nowb;
   logic       w_illegal;
   logic       w_flag_upd;
   logic       w_taken;

   assign w_code = funct[4:0];
   assign w_sub  = funct[FUNCT_W-1:FUNCT_W-4];

   // Op=1 subtypes: 0 JE, 1 JB, 2 JA, 3 JL, 4 JG, 5 JMP, 6 LI, 7 LM
   assign w_is_lm    = op && (w_sub == 4'd7);
   assign w_is_li    = op && (w_sub == 4'd6);
   assign w_is_br    = op && (w_sub < 4'd6);
   assign w_is_xchg  = !op && (w_code == 5'd7);
   // NOP=0, ShowR=18, ShowRSeg=19, CMP=20 finish in EXEC with no write-back
   assign w_is_nowb  = !op && ((w_code == 5'd0) || (w_code == 5'd18) ||
                               (w_code == 5'd19) || (w_code == 5'd20));
   assign w_illegal  = op ? w_sub[3] : ((w_code == 5'd17) || (w_code > 5'd20));
   assign w_flag_upd = !op && (((w_code >= 5'd1) && (w_code <= 5'd5)) ||
                               ((w_code >= 5'd9) && (w_code <= 5'd16)) ||
                               (w_code == 5'd20));

   always_comb begin
      w_taken = 1'b0;
      case (w_sub[2:0])
         3'd0:    w_taken = r_flags[2];
         3'd1:    w_taken = r_flags[1];
         3'd2:    w_taken = !r_flags[1] && !r_flags[2];
         3'd3:    w_taken = r_flags[3] ^ r_flags[0];
         3'd4:    w_taken = !r_flags[2] && !(r_flags[3] ^ r_flags[0]);
         3'd5:    w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_flags   <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_EXEC && w_flag_upd)
            r_flags <= alu_flags;
         if (r_state == S_DECODE && w_illegal)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = imem_ready ? S_DECODE : S_FETCH;
         S_DECODE: w_next = w_illegal ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (w_is_lm)
               w_next = S_MEM;
            else if (w_is_br || w_is_nowb)
               w_next = S_FETCH;
            else
               w_next = S_WB;
         end
         S_MEM:    w_next = mem_ready ? S_WB : S_MEM;
         S_WB:     w_next = w_is_xchg ? S_WB2 : S_FETCH;
         S_WB2:    w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   always_comb begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      alu_src       = 1'b0;
      alu_control   = '0;
      imm_src       = 1'b0;
      mem_read      = 1'b0;
      reg_write     = 1'b0;
      reg_write_sel = 1'b0;
      wb_src        = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_EXEC: begin
            if (!op)
               alu_control = ALUCTL_W'(w_code);
            else if (w_is_lm)
               alu_control = ALUCTL_W'(22);
            else if (w_is_li)
               alu_control = ALUCTL_W'(21);
            else
               alu_control = ALUCTL_W'(1);
            alu_src = (!op && w_code[3]) || w_is_li;
            imm_src = w_is_li || w_is_br;
            if (w_is_br && w_taken) begin
               pc_write = 1'b1;
               pc_src   = 1'b1;
            end
         end
         S_MEM: mem_read = 1'b1;
         S_WB: begin
            reg_write = 1'b1;
            wb_src    = w_is_lm;
         end
         S_WB2: begin
            reg_write     = 1'b1;
            reg_write_sel = 1'b1;
         end
         default: ;
      endcase
   end

   assign flags_q = r_flags;
   assign illegal = r_illegal;
   assign busy    = (r_state != S_FETCH);

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by cycle
// against hand-computed strobe vectors.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       op;
   logic [8:0] funct;
   logic       imem_ready;
   logic       mem_ready;
   logic [3:0] alu_flags;
   logic       ir_write, pc_write, pc_src, alu_src, imm_src, mem_read;
   logic       reg_write, reg_write_sel, wb_src, illegal, busy;
   logic [4:0] alu_control;
   logic [3:0] flags_q;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mc_control_unit #(.FUNCT_W(9), .ALUCTL_W(5), .FLAG_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct),
      .imem_ready(imem_ready), .mem_ready(mem_ready), .alu_flags(alu_flags),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
      .alu_control(alu_control), .imm_src(imm_src), .mem_read(mem_read),
      .reg_write(reg_write), .reg_write_sel(reg_write_sel), .wb_src(wb_src),
      .flags_q(flags_q), .illegal(illegal), .busy(busy)
   );

   // {ir_write,pc_write,pc_src,alu_src,imm_src,mem_read,reg_write,reg_write_sel,wb_src,illegal,busy}
   logic [10:0] w_obs;
   assign w_obs = {ir_write, pc_write, pc_src, alu_src, imm_src, mem_read,
                   reg_write, reg_write_sel, wb_src, illegal, busy};

   localparam logic [10:0] V_IDLE  = 11'b000_0000_0000;
   localparam logic [10:0] V_FETCH = 11'b110_0000_0000;
   localparam logic [10:0] V_DEC   = 11'b000_0000_0001;
   localparam logic [10:0] V_EXEC  = 11'b000_0000_0001;
   localparam logic [10:0] V_EXALU = 11'b000_1000_0001;
   localparam logic [10:0] V_BR_T  = 11'b011_0100_0001;
   localparam logic [10:0] V_BR_NT = 11'b000_0100_0001;
   localparam logic [10:0] V_EX_LI = 11'b000_1100_0001;
   localparam logic [10:0] V_MEM   = 11'b000_0010_0001;
   localparam logic [10:0] V_WB    = 11'b000_0001_0001;
   localparam logic [10:0] V_WB2   = 11'b000_0001_1001;
   localparam logic [10:0] V_WB_LM = 11'b000_0001_0101;
   localparam logic [10:0] V_HALT  = 11'b000_0000_0011;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic look(input string tag, input logic [10:0] exp);
      #1;
      chk(tag, 32'(w_obs), 32'(exp));
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [10:0] exp);
      look(tag, exp);
      adv();
   endtask

   initial begin
      reset = 1'b1; op = 1'b0; funct = '0; imem_ready = 1'b0;
      mem_ready = 1'b0; alu_flags = '0;
      #3;
      look("rst_out", V_IDLE);
      chk("rst_flags", 32'(flags_q), 32'h0);
      adv();
      reset = 1'b0;

      // ADD: 4 cycles, flags load on leaving EXEC
      op = 1'b0; funct = 9'h001; alu_flags = 4'b0100; imem_ready = 1'b1;
      cyc("add_fetch", V_FETCH);
      cyc("add_dec", V_DEC);
      look("add_exec", V_EXEC);
      chk("add_aluctl", 32'(alu_control), 32'd1);
      chk("add_flags_pre", 32'(flags_q), 32'h0);
      adv();
      look("add_wb", V_WB);
      chk("add_flags", 32'(flags_q), 32'b0100);
      adv();

      // CMP (Z set) then JE taken; JE uses registered flags, not alu_flags
      funct = 9'h014;
      cyc("cmp1_fetch", V_FETCH);
      cyc("cmp1_dec", V_DEC);
      look("cmp1_exec", V_EXEC);
      chk("cmp1_aluctl", 32'(alu_control), 32'd20);
      adv();
      op = 1'b1; funct = 9'h000; alu_flags = 4'b0000;
      cyc("je1_fetch", V_FETCH);
      cyc("je1_dec", V_DEC);
      look("je1_exec", V_BR_T);
      chk("je1_aluctl", 32'(alu_control), 32'd1);
      adv();

      // CMP (Z clear) then JE not taken, JA taken
      op = 1'b0; funct = 9'h014; alu_flags = 4'b0000;
      cyc("cmp2_fetch", V_FETCH);
      cyc("cmp2_dec", V_DEC);
      cyc("cmp2_exec", V_EXEC);
      chk("cmp2_flags", 32'(flags_q), 32'h0);
      op = 1'b1; funct = 9'h000; alu_flags = 4'b0100;
      cyc("je2_fetch", V_FETCH);
      cyc("je2_dec", V_DEC);
      cyc("je2_exec", V_BR_NT);
      funct = 9'h040;
      cyc("ja_fetch", V_FETCH);
      cyc("ja_dec", V_DEC);
      cyc("ja_exec", V_BR_T);

      // XCHG: two write-back cycles, flags untouched
      op = 1'b0; funct = 9'h007; alu_flags = 4'b1111;
      cyc("xchg_fetch", V_FETCH);
      cyc("xchg_dec", V_DEC);
      cyc("xchg_exec", V_EXEC);
      cyc("xchg_wb", V_WB);
      look("xchg_wb2", V_WB2);
      chk("xchg_flags", 32'(flags_q), 32'h0);
      adv();

      // LI: immediate operand and format, one write-back
      op = 1'b1; funct = 9'h0C0;
      cyc("li_fetch", V_FETCH);
      cyc("li_dec", V_DEC);
      look("li_exec", V_EX_LI);
      chk("li_aluctl", 32'(alu_control), 32'd21);
      adv();
      cyc("li_wb", V_WB);

      // LM with three wait cycles: 8 cycles total
      funct = 9'h0E0; mem_ready = 1'b0;
      cyc("lm_fetch", V_FETCH);
      cyc("lm_dec", V_DEC);
      look("lm_exec", V_EXEC);
      chk("lm_aluctl", 32'(alu_control), 32'd22);
      adv();
      cyc("lm_mem0", V_MEM);
      cyc("lm_mem1", V_MEM);
      cyc("lm_mem2", V_MEM);
      mem_ready = 1'b1;
      cyc("lm_mem3", V_MEM);
      mem_ready = 1'b0;
      cyc("lm_wb", V_WB_LM);

      // FETCH stalls while instruction memory is not ready
      op = 1'b0; funct = 9'h000; imem_ready = 1'b0;
      cyc("stall0", V_IDLE);
      cyc("stall1", V_IDLE);
      imem_ready = 1'b1;
      cyc("nop_fetch", V_FETCH);
      cyc("nop_dec", V_DEC);
      cyc("nop_exec", V_EXEC);

      // Reset during XCHG write-back aborts the second write
      funct = 9'h007;
      cyc("xr_fetch", V_FETCH);
      cyc("xr_dec", V_DEC);
      cyc("xr_exec", V_EXEC);
      look("xr_wb", V_WB);
      imem_ready = 1'b0; reset = 1'b1;
      look("xr_rst", V_IDLE);
      adv();
      reset = 1'b0;
      cyc("xr_after0", V_IDLE);
      cyc("xr_after1", V_IDLE);

      // Illegal ALU code 17 parks in HALT
      imem_ready = 1'b1; funct = 9'h011;
      cyc("ill_fetch", V_FETCH);
      cyc("ill_dec", V_DEC);
      for (int i = 0; i < 10; i++)
         cyc($sformatf("ill_halt%0d", i), V_HALT);
      reset = 1'b1;
      look("ill_rst", V_FETCH);
      adv();
      reset = 1'b0;

      // Illegal Op=1 subtype 8
      op = 1'b1; funct = 9'h100;
      cyc("ill1_fetch", V_FETCH);
      cyc("ill1_dec", V_DEC);
      cyc("ill1_halt", V_HALT);
      imem_ready = 1'b0; reset = 1'b1;
      look("ill1_rst", V_IDLE);
      adv();
      reset = 1'b0;
      cyc("final_idle", V_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle successor to the single-cycle instruction decoder. It decodes the same Op/Funct instruction fields but sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It owns the architectural flag register and evaluates branch conditions internally. XCHG is serialised into two write-back cycles, and LM waits on a memory-ready handshake. It sits between the instruction register and the datapath (PC, register file, ALU, data memory).

Parameters:
FUNCT_W, 9, width of the Funct field; [4:0] is the ALU code, [FUNCT_W-1:FUNCT_W-4] is the Op=1 subtype.
ALUCTL_W, 5, width of alu_control; must be >= 5.
FLAG_W, 4, flag register width, fixed order {S,Z,C,O}; only 4 is supported.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  1  instruction class from the IR (0 = data-processing, 1 = branch/load)
funct  in  FUNCT_W  function field from the IR
imem_ready  in  1  instruction memory has valid data this cycle
mem_ready  in  1  data memory read complete (LM)
alu_flags  in  FLAG_W  {S,Z,C,O} from the ALU, valid in the EXEC cycle
ir_write  out  1  load the IR
pc_write  out  1  update the PC
pc_src  out  1  0 = PC+1, 1 = branch target
alu_src  out  1  1 = immediate operand
alu_control  out  ALUCTL_W  ALU operation, valid in EXEC
imm_src  out  1  immediate format select
mem_read  out  1  data memory read request
reg_write  out  1  register file write enable
reg_write_sel  out  1  0 = first destination, 1 = second destination (XCHG)
wb_src  out  1  0 = ALU result, 1 = memory data
flags_q  out  FLAG_W  registered flags {S,Z,C,O}
illegal  out  1  sticky flag: an unimplemented encoding was decoded
busy  out  1  high in every state except FETCH

Behaviour:
- The clock and reset are fixed: one clock, clk. The reset, reset, is asynchronous and active-high.
- Reset puts the FSM in FETCH and clears flags_q to 0 and illegal to 0.
- All outputs are combinational from the state and the decoded op/funct. Outside the listed conditions every output is 0; pc_src and wb_src are also 0.
- FETCH:
  - If imem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, next state DECODE.
  - Otherwise hold in FETCH with no strobes.
- DECODE: one cycle, no strobes. Legality is checked here; an illegal encoding goes to HALT and sets illegal.
  - Op=0: legal ALU codes are 0–16 and 18–20. Codes 17 and 21–31 are illegal.
  - Op=1: subtype 8–15 is illegal.
- EXEC:
  - alu_control is the zero-extended ALU code for Op=0; 21 (LI) or 22 (LM); 1 for branches.
  - alu_src = 1 for INC, DEC (code[3] = 1) and for LI.
  - imm_src = 1 for LI and for branches.
- Flag update in EXEC:
  - The flag-updating ALU codes are 1–5, 9–16 and 20.
  - For those codes, {S,Z} and {C,O} both load from alu_flags on the clock edge leaving EXEC.
  - No other instruction modifies flags_q.
- Branches, resolved in EXEC using flags_q before any update:
  - JE = Z; JB = C; JA = !C & !Z; JL = S^O; JG = !Z & !(S^O); JMP = 1.
  - If taken: pc_write = 1, pc_src = 1.
  - Next state is FETCH.
- Instructions that return to FETCH after EXEC with no write: NOP, CMP, ShowR, ShowRSeg.
- Register ops and LI: WB, reg_write = 1, reg_write_sel = 0, then FETCH.
- XCHG (code 7):
  - WB with reg_write_sel = 0, then WB2 with reg_write = 1 and reg_write_sel = 1, then FETCH.
  - The register file must not see both writes in one cycle.
- LM:
  - EXEC goes to MEM. MEM asserts mem_read and holds until mem_ready = 1.
  - Then WB with wb_src = 1, then FETCH.
  - mem_ready is ignored in every other state.
- HALT: absorbing state. All strobes are 0, illegal = 1, busy = 1; only reset exits.
- Cycle counts, imem_ready and mem_ready held high:
  - Branch, NOP, CMP: 3.
  - ALU op, LI: 4.
  - XCHG, LM: 5.
  - Each extra wait cycle adds 1.
- Reset mid-instruction aborts immediately. No partial write strobe may be emitted after reset deasserts; the FSM restarts in FETCH.

Test Plan:
- Reset, then ADD (op=0, funct=9'h001) with alu_flags=4'b0100 and imem_ready high -> 4 cycles; reg_write high only in cycle 4; flags_q=4'b0100 after EXEC.
- CMP with alu_flags=4'b0100, then JE -> JE has pc_write=1, pc_src=1 in its EXEC cycle. Repeat with flags 4'b0000 -> pc_write=0 in EXEC.
- XCHG (funct=9'h007) -> reg_write high in two consecutive cycles with reg_write_sel 0 then 1; flags_q unchanged.
- LM (op=1, funct[8:5]=7) with mem_ready low for 3 cycles -> mem_read high for 4 cycles; WB has wb_src=1; total 8 cycles.
- Illegal funct=9'h011 -> HALT; illegal=1 and no strobes for 10 cycles; reset returns to FETCH with illegal=0.
- imem_ready low for 2 cycles in FETCH -> no ir_write until it rises. Assert reset during the WB of an XCHG -> no reg_write after deassertion until a new instruction is fetched.
